// File: rtl/rs_syndrome.sv
// RS syndrome calculator: W symbols per beat, one Horner chain per root.
// GF constants and constant-multiplier helpers live in gf_pkg below.
package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int POLY = 285;
  localparam int N_LEN = 255;
  localparam int K_LEN = 239;
  localparam int BUS_WIDTH_IN_SYMB = 4;
  localparam int FIRST_ROOT = 1;
  localparam int ROOTS_NUM = N_LEN - K_LEN;
  localparam int CYCLES =
    (N_LEN + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB;
  localparam int CNT_W = $clog2(CYCLES + 1);

  typedef logic [SYMB_WIDTH-1:0] sym_t;
  typedef logic [SYMB_WIDTH*SYMB_WIDTH-1:0] cmat_t;

  function automatic sym_t gf_xtime(sym_t a);
    sym_t r;
    r = {a[SYMB_WIDTH-2:0], 1'b0};
    if (a[SYMB_WIDTH-1]) r = r ^ sym_t'(POLY);
    return r;
  endfunction

  function automatic sym_t gf_pow(int e);
    sym_t r;
    int n;
    r = sym_t'(1);
    n = e % ((1 << SYMB_WIDTH) - 1);
    for (int i = 0; i < n; i++) r = gf_xtime(r);
    return r;
  endfunction

  // Column i holds alpha^(e+i): the image of basis bit i.
  function automatic cmat_t gf_cmat(int e);
    cmat_t m;
    sym_t c;
    c = gf_pow(e);
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      m[i*SYMB_WIDTH +: SYMB_WIDTH] = c;
      c = gf_xtime(c);
    end
    return m;
  endfunction

  function automatic sym_t gf_cmul(cmat_t m, sym_t d);
    sym_t r;
    r = '0;
    for (int i = 0; i < SYMB_WIDTH; i++)
      if (d[i]) r = r ^ m[i*SYMB_WIDTH +: SYMB_WIDTH];
    return r;
  endfunction
endpackage

module rs_syndrome
  import gf_pkg::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  logic s_tvalid,
  output logic s_tready,
  input  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] s_tdata,
  input  logic [BUS_WIDTH_IN_SYMB-1:0] s_tkeep,
  input  logic s_tlast,
  output logic synd_valid,
  input  logic synd_ready,
  output logic [ROOTS_NUM*SYMB_WIDTH-1:0] synd,
  output logic synd_nonzero,
  output logic len_err
);
  localparam int W = BUS_WIDTH_IN_SYMB;
  localparam int SW = SYMB_WIDTH;
  localparam int R = ROOTS_NUM;
  localparam int MW = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_CYC = CNT_W'(CYCLES);

  typedef enum logic {EMPTY, FULL} ostate_e;

  ostate_e state_q, state_d;
  logic sop_q, sop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_beat;
  logic [R*SW-1:0] acc_q, acc_d;
  logic [R*SW-1:0] synd_q, synd_d;
  logic nz_q, nz_d;
  logic lerr_q, lerr_d;
  logic [R*SW-1:0] fold;
  logic [MW-1:0] m_dec, m_use;
  logic accept, last_acc;

  assign s_tready = (state_q == EMPTY) | synd_ready;
  assign accept = s_tvalid & s_tready;
  assign last_acc = accept & s_tlast;

  // Only a contiguous, non-empty leading mask shortens the beat.
  always_comb begin
    m_dec = MW'(W);
    for (int q = 1; q <= W; q++)
      if (s_tkeep == W'((1 << q) - 1)) m_dec = MW'(q);
  end

  assign m_use = s_tlast ? m_dec : MW'(W);

  for (genvar j = 0; j < R; j++) begin : g_root
    localparam cmat_t M = gf_cmat(FIRST_ROOT + j);
    sym_t h [W+1];
    always_comb begin
      h[0] = sop_q ? '0 : acc_q[j*SW +: SW];
      for (int k = 0; k < W; k++)
        h[k+1] = gf_cmul(M, h[k]) ^ s_tdata[k*SW +: SW];
    end
    assign fold[j*SW +: SW] = h[m_use];
  end

  always_comb begin
    if (sop_q) cnt_beat = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_beat = cnt_q;
    else cnt_beat = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sop_d = sop_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    synd_d = synd_q;
    nz_d = nz_q;
    lerr_d = lerr_q;
    if (accept) begin
      sop_d = s_tlast;
      cnt_d = cnt_beat;
      acc_d = fold;
    end
    if (last_acc) begin
      synd_d = fold;
      nz_d = |fold;
      lerr_d = (cnt_beat != CNT_CYC);
    end
    unique case (state_q)
      EMPTY: if (last_acc) state_d = FULL;
      FULL: if (synd_ready && !last_acc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      sop_q <= 1'b1;
      cnt_q <= '0;
      acc_q <= '0;
      synd_q <= '0;
      nz_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sop_q <= sop_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      synd_q <= synd_d;
      nz_q <= nz_d;
      lerr_q <= lerr_d;
    end
  end

  assign synd_valid = (state_q == FULL);
  assign synd = synd_q;
  assign synd_nonzero = nz_q;
  assign len_err = lerr_q;
endmodule

// File: tb/tb_rs_syndrome.sv
// Bench for rs_syndrome: polynomial-evaluation model plus directed
// codewords (zero, encoded, corrupted, short, stalled, reset-aborted).
module tb_rs_syndrome;
  import gf_pkg::*;
  localparam int W = BUS_WIDTH_IN_SYMB;
  localparam int SW = SYMB_WIDTH;
  localparam int R = ROOTS_NUM;
  localparam int NB = (N_LEN + W - 1) / W;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tready;
  logic [W*SW-1:0] s_tdata = '0;
  logic [W-1:0] s_tkeep = '0;
  logic s_tlast = 1'b0;
  logic synd_valid;
  logic synd_ready = 1'b1;
  logic [R*SW-1:0] synd;
  logic synd_nonzero;
  logic len_err;

  always #5 aclk = ~aclk;

  rs_syndrome dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tkeep(s_tkeep),
    .s_tlast(s_tlast),
    .synd_valid(synd_valid),
    .synd_ready(synd_ready),
    .synd(synd),
    .synd_nonzero(synd_nonzero),
    .len_err(len_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent GF(256) arithmetic, poly x^8+x^4+x^3+x^2+1.
  logic [7:0] alog [255];

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  typedef struct {
    logic [R*SW-1:0] s;
    logic nz;
    logic le;
  } set_t;

  logic [7:0] cur_syms [$];
  int cur_beats = 0;
  set_t exp_q [$];
  int sets_seen = 0;
  logic [R*SW-1:0] got_synd;
  logic got_nz, got_le;

  // Received symbols form c(x) with the first symbol as top coefficient.
  function automatic set_t model_set();
    set_t r;
    int L;
    logic [7:0] s;
    L = cur_syms.size();
    r.s = '0;
    r.nz = 1'b0;
    for (int j = 0; j < R; j++) begin
      s = 8'h00;
      for (int i = 0; i < L; i++)
        s = s ^ gmul(cur_syms[i],
                     alog[((FIRST_ROOT + j) * (L - 1 - i)) % 255]);
      r.s[j*SW +: SW] = s;
      if (s != 8'h00) r.nz = 1'b1;
    end
    r.le = (cur_beats != NB);
    return r;
  endfunction

  always @(negedge aclk) begin
    int m;
    set_t e;
    if (!aresetn) begin
      cur_syms.delete();
      cur_beats = 0;
      exp_q.delete();
      check("rst_valid", synd_valid, 1'b0);
      check("rst_synd", synd, '0);
      check("rst_flags", {synd_nonzero, len_err}, 2'b00);
    end else begin
      check("tready", s_tready, !synd_valid || synd_ready);
      check("valid", synd_valid, exp_q.size() != 0);
      if (synd_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        check("synd", synd, e.s);
        check("nonzero", synd_nonzero, e.nz);
        check("len_err", len_err, e.le);
      end
      if (synd_valid && synd_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got_synd = synd;
        got_nz = synd_nonzero;
        got_le = len_err;
        sets_seen++;
      end
      if (s_tvalid && s_tready) begin
        m = W;
        if (s_tlast)
          for (int q = 1; q <= W; q++)
            if (s_tkeep == W'((1 << q) - 1)) m = q;
        for (int k = 0; k < m; k++)
          cur_syms.push_back(s_tdata[k*SW +: SW]);
        cur_beats++;
        if (s_tlast) begin
          exp_q.push_back(model_set());
          cur_syms.delete();
          cur_beats = 0;
        end
      end
    end
  end

  task automatic beat(input logic [W*SW-1:0] d, input logic [W-1:0] k,
                      input logic l);
    int n = 0;
    logic ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    while (!ok && n < 300) begin
      @(negedge aclk);
      ok = s_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got 0 want 1");
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  logic [7:0] cw [255];
  logic [7:0] gen [17];

  task automatic make_cw();
    logic [7:0] msg [239];
    for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 239; a++)
      for (int b = 0; b <= 16; b++)
        cw[a+b] = cw[a+b] ^ gmul(msg[a], gen[b]);
  endtask

  // Sends c[254] first; stops before beat abort_at when abort_at >= 0.
  task automatic send_cw(input int nbeats, input int abort_at);
    logic [W*SW-1:0] d;
    logic [W-1:0] k;
    int n, nv;
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_at) return;
      for (int l = 0; l < W; l++) begin
        n = b * W + l;
        d[l*SW +: SW] = (n < 255) ? cw[254-n] : 8'hff;
      end
      nv = 255 - b * W;
      if (nv > W) nv = W;
      k = (b == nbeats - 1) ? W'((1 << nv) - 1) : '1;
      beat(d, k, b == nbeats - 1);
    end
  endtask

  task automatic wait_set(input int prev);
    int n = 0;
    while (sets_seen <= prev && n < 1000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    if (sets_seen <= prev) begin
      checks++;
      errors++;
      $display("FAIL set_timeout got %0d want %0d", sets_seen, prev + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int p;
    logic [7:0] a;
    logic [7:0] ng [17];
    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = a;
      a = xt(a);
    end
    for (int i = 0; i < 17; i++) gen[i] = 8'h00;
    gen[0] = 8'h01;
    for (int r = 1; r <= 16; r++) begin
      for (int d = 0; d <= 16; d++)
        ng[d] = ((d > 0) ? gen[d-1] : 8'h00) ^ gmul(alog[r], gen[d]);
      gen = ng;
    end

    check("alog1", alog[1], 8'h02);
    check("alog8", alog[8], 8'h1d);
    check("alog_wrap", gmul(alog[254], 8'h02), 8'h01);

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", s_tready, 1'b1);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_tready", s_tready, 1'b1);
    check("post_rst_valid", synd_valid, 1'b0);

    // single symbol 0x01: c(x)=1
    p = sets_seen;
    beat(32'heeddcc01, 4'b0001, 1'b1);
    idle();
    wait_set(p);
    check("one_s0", got_synd[7:0], 8'h01);
    check("one_s15", got_synd[127:120], 8'h01);
    check("one_le", got_le, 1'b1);
    check("one_nz", got_nz, 1'b1);

    // c(x)=x: S_j = alpha^(1+j)
    p = sets_seen;
    beat(32'h77660001, 4'b0011, 1'b1);
    idle();
    wait_set(p);
    check("x_s0", got_synd[7:0], 8'h02);
    check("x_s7", got_synd[63:56], 8'h1d);

    // noncontiguous keep acts as full beat
    p = sets_seen;
    beat(32'h04030201, 4'b0101, 1'b1);
    idle();
    wait_set(p);

    // all-zero codeword
    for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    p = sets_seen;
    send_cw(NB, -1);
    idle();
    wait_set(p);
    check("zero_synd", got_synd, '0);
    check("zero_nz", got_nz, 1'b0);
    check("zero_le", got_le, 1'b0);

    // clean encoded codeword, then single error 0x5A at degree 200
    make_cw();
    p = sets_seen;
    send_cw(NB, -1);
    idle();
    wait_set(p);
    check("clean_synd", got_synd, '0);
    cw[200] = cw[200] ^ 8'h5a;
    p = sets_seen;
    send_cw(NB, -1);
    idle();
    wait_set(p);
    for (int j = 0; j < R; j++)
      check($sformatf("err_s%0d", j), got_synd[j*SW +: SW],
            gmul(8'h5a, alog[(200 * (1 + j)) % 255]));
    check("err_nz", got_nz, 1'b1);
    check("err_le", got_le, 1'b0);

    // back-to-back, valid held high
    p = sets_seen;
    make_cw();
    send_cw(NB, -1);
    cw[17] = cw[17] ^ 8'h33;
    send_cw(NB, -1);
    idle();
    wait_set(p + 1);
    check("b2b_count", sets_seen, p + 2);

    // consumer stalls 10 cycles after first set
    p = sets_seen;
    fork
      begin
        make_cw();
        cw[3] = cw[3] ^ 8'h81;
        send_cw(NB, -1);
        cw[250] = cw[250] ^ 8'h07;
        send_cw(NB, -1);
        idle();
      end
      begin
        int n = 0;
        while (!synd_valid && n < 1000) begin
          @(posedge aclk);
          #1;
          n++;
        end
        synd_ready = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        synd_ready = 1'b1;
      end
    join
    wait_set(p + 1);
    check("stall_count", sets_seen, p + 2);

    // early tlast, then a correct codeword
    for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    p = sets_seen;
    send_cw(NB - 1, -1);
    idle();
    wait_set(p);
    check("short_le", got_le, 1'b1);
    p = sets_seen;
    send_cw(NB, -1);
    idle();
    wait_set(p);
    check("after_short_le", got_le, 1'b0);

    // reset at beat 30 of a nonzero codeword
    make_cw();
    cw[100] = 8'hff;
    p = sets_seen;
    send_cw(NB, 30);
    idle();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    send_cw(NB, -1);
    idle();
    wait_set(p);
    check("abort_count", sets_seen, p + 1);
    check("abort_synd", got_synd, '0);
    check("abort_le", got_le, 1'b0);

    repeat (5) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_syndrome.md
RS_SYNDROME -- requirements
Module: rs_syndrome

Interface
REQ-001 SHALL take parameters from gf_pkg: SYMB_WIDTH (8), POLY (285), N_LEN (255), K_LEN (239), BUS_WIDTH_IN_SYMB = W (4), FIRST_ROOT (1), ROOTS_NUM = N_LEN-K_LEN (16).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports (name  direction  width  meaning):
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid & s_tready
- s_tdata  in  W*SYMB_WIDTH  lane k = bits [k*SYMB_WIDTH +: SYMB_WIDTH]; lane 0 = earliest symbol
- s_tkeep  in  W  lane valid mask; all-ones except on the tlast beat
- s_tlast  in  1  last beat of codeword
- synd_valid  out  1  syndrome set available
- synd_ready  in  1  consumer accepts syndrome set
- synd  out  ROOTS_NUM*SYMB_WIDTH  S_j = bits [j*SYMB_WIDTH +: SYMB_WIDTH]
- synd_nonzero  out  1  OR of all S_j != 0
- len_err  out  1  beat count on tlast != CYCLES = ceil(N_LEN/W)

Function
REQ-004 The first received symbol SHALL be coefficient c[N_LEN-1]; the last SHALL be c[0].
REQ-005 S_j SHALL equal c(alpha^(FIRST_ROOT+j)), j = 0..ROOTS_NUM-1, using GF(2^SYMB_WIDTH) with primitive polynomial POLY.
REQ-006 On each accepted full beat: A_j <= A_j*alpha^(r_j*W) XOR sum_{k=0..W-1} d_k*alpha^(r_j*(W-1-k)), with r_j = FIRST_ROOT+j.
REQ-007 On a tlast beat with m = popcount(s_tkeep) valid leading lanes (0..m-1): A_j <= A_j*alpha^(r_j*m) XOR sum_{k<m} d_k*alpha^(r_j*(m-1-k)).
REQ-008 Non-contiguous s_tkeep, or m = 0, SHALL be treated as m = W; no other effect.
REQ-009 All constant multipliers SHALL be constant-GF multiplications elaborated from the gf_pkg tables; there SHALL be no general multipliers.
REQ-010 The first beat of a codeword (sop flag set) SHALL use A_j = 0 as prior value, so back-to-back codewords need no idle cycle.
REQ-011 sop SHALL be set at reset and after each accepted tlast beat, and cleared by any other accepted beat.
REQ-012 A beat counter SHALL count accepted beats within a codeword: width $clog2(CYCLES+1), saturating at max, reset to 1 on sop beat.
REQ-013 On an accepted tlast beat, the next cycle SHALL assert synd_valid with synd = final A_j, synd_nonzero, and len_err; latency is 1 cycle.
REQ-014 synd, synd_nonzero and len_err SHALL be held stable while synd_valid & !synd_ready.
REQ-015 synd_valid SHALL clear on the cycle after synd_valid & synd_ready unless a new tlast beat is accepted in the same cycle; in that case it stays high with the new set.
REQ-016 s_tready SHALL equal !synd_valid | synd_ready, combinational from registered state and synd_ready only, with no dependence on s_tvalid.
REQ-017 Output states: EMPTY (synd_valid = 0) and FULL (synd_valid = 1).
- EMPTY->FULL on tlast accept.
- FULL->EMPTY on synd_ready without tlast accept.
- FULL->FULL on synd_ready with tlast accept.
REQ-018 A tlast beat with no prior beat (single-beat codeword) SHALL be processed per REQ-007/010 and flag len_err unless CYCLES = 1.

Reset
REQ-019 While aresetn = 0: synd_valid = 0, synd = 0, synd_nonzero = 0, len_err = 0, accumulators = 0, sop = 1, beat counter = 0.
REQ-020 s_tready SHALL be 1 after reset.
REQ-021 Reset mid-codeword SHALL discard the partial codeword; the first beat after reset starts a new codeword.
REQ-022 Deassertion of aresetn SHALL be synchronized externally; the block needs no internal synchronizer.

Verification
REQ-023 All-zero 255-symbol codeword (64 beats, last s_tkeep = 4'b0111) -> one synd_valid pulse, all S_j = 0, synd_nonzero = 0, len_err = 0.
REQ-024 Valid RS(255,239) codeword plus single error value 0x5A at degree 200 -> S_j = 0x5A*alpha^(200*(1+j)) for all 16 j, synd_nonzero = 1.
REQ-025 Two codewords back-to-back with s_tvalid held high and synd_ready = 1 -> two correct syndrome sets on consecutive tlast+1 cycles, no beat dropped.
REQ-026 synd_ready = 0 for 10 cycles after the first set while the second codeword streams -> s_tready drops only while synd_valid & !synd_ready; the first set stays stable; the second set is correct.
REQ-027 Codeword of 63 beats (tlast early) -> len_err = 1; the next correct codeword reports len_err = 0.
REQ-028 aresetn pulsed low at beat 30 of a codeword, then a full zero codeword sent -> no output for the aborted codeword; the next set has all S_j = 0 and len_err = 0.
